// File: rtl/switch_arbiter_pkg.sv
// Shared NoC definitions: default sizes, flit type encoding, direction indices
// and the arbiter FSM state type.
package switch_arbiter_pkg;

  localparam int NOC_NUM_IN    = 5;
  localparam int NOC_FLIT_W    = 34;
  localparam int NOC_OUT_DEPTH = 4;
  localparam int NOC_IDX_W     = 3;

  // Flit type lives in the top two bits of every flit
  localparam int TYPE_HI = NOC_FLIT_W - 1;
  localparam int TYPE_LO = NOC_FLIT_W - 2;

  // Router direction indices
  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;
  localparam int DIR_L = 4;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // A flit may open a new packet only if it is a HEAD or a SINGLE
  function automatic logic starts_packet(input logic [1:0] ftype);
    return (ftype == FT_HEAD) || (ftype == FT_SINGLE);
  endfunction

endpackage

// File: rtl/switch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester after ptr (modulo
// NUM_IN) wins, so the previous winner ends up with the lowest priority.
module rr_arbiter #(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  // Scan ptr+1, ptr+2, ... and keep the first requesting input
  always_comb begin
    int cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = (int'(ptr) + k) % NUM_IN;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/switch_arbiter.sv
// Wormhole switch arbiter for one router output: round-robin grant, packet
// lock from HEAD to TAIL, credit flow control and a registered flit mux.
module switch_arbiter
  import switch_arbiter_pkg::*;
#(
  parameter int NUM_IN    = NOC_NUM_IN,
  parameter int FLIT_W    = NOC_FLIT_W,
  parameter int OUT_DEPTH = NOC_OUT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_req,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  output logic [NUM_IN-1:0]        in_pop,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_valid,
  input  logic                     credit_in,
  output logic                     busy,
  output logic [2:0]               owner,
  output logic                     err
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int IDX_W = 3;

  arb_state_e        state, state_next;
  logic [IDX_W-1:0]  rr_ptr, rr_next, owner_next, sel;
  logic [CNT_W-1:0]  credits;
  logic [FLIT_W-1:0] flit_arr [NUM_IN];
  logic [1:0]        ftype    [NUM_IN];
  logic [NUM_IN-1:0] eligible, bad_head, arb_gnt, pop_raw;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any, send_ok, pop, err_set, credit_err;

  // Unpack the flit bus and classify each requesting head flit
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      flit_arr[i] = in_flit[i*FLIT_W +: FLIT_W];
      ftype[i]    = flit_arr[i][FLIT_W-1 -: 2];
      eligible[i] = in_req[i] && starts_packet(ftype[i]);
      bad_head[i] = in_req[i] && !starts_packet(ftype[i]);
    end
  end

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign send_ok = (credits != '0);
  assign busy    = (state == ST_LOCKED);

  // Grant/lock decisions; pops only ever happen while a credit is available
  always_comb begin
    state_next = state;
    pop_raw    = '0;
    sel        = owner;
    owner_next = owner;
    rr_next    = rr_ptr;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|bad_head) err_set = 1'b1;
        if (send_ok && arb_any) begin
          pop_raw    = arb_gnt;
          sel        = arb_idx;
          owner_next = arb_idx;
          rr_next    = arb_idx;
          if (ftype[arb_idx] == FT_HEAD) state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (in_req[owner] && send_ok) begin
          pop_raw[owner] = 1'b1;
          if (ftype[owner] == FT_TAIL) state_next = ST_IDLE;
          else if (starts_packet(ftype[owner])) err_set = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Hold pops off while reset is asserted so the input FIFOs never lose a flit
  assign in_pop = pop_raw & {NUM_IN{reset}};
  assign pop    = |in_pop;
  assign credit_err = credit_in && !pop && (credits == CNT_W'(OUT_DEPTH));

  // FSM state, round-robin pointer and owner registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      rr_ptr <= IDX_W'(NUM_IN - 1);
      owner  <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
      owner  <= owner_next;
    end
  end

  // Credit counter: a pop consumes a slot, credit_in returns one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= CNT_W'(OUT_DEPTH);
    end else if (pop && !credit_in) begin
      credits <= credits - 1'b1;
    end else if (credit_in && !pop && !credit_err) begin
      credits <= credits + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if (err_set || credit_err) err <= 1'b1;
  end

  // Output register: a flit popped this cycle is presented next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else begin
      out_valid <= pop;
      if (pop) out_flit <= flit_arr[sel];
    end
  end

endmodule
